// File: rtl/fas_peak_detect.sv
// fas_peak_detect
//   Frequency-analysis stage that follows the 16-point FFT. Each accepted frame of 16 complex
//   bins is scanned one bin per cycle, computing re^2 + im^2 and tracking the strongest bin.
//   When the scan finishes, done pulses for one cycle and freq/peak_mag carry the result
//   until the next done. A one-deep pending buffer lets a new frame arrive while the engine
//   is still scanning, so frames spaced 16 cycles apart run back-to-back.
//
// Parameters
//   DW       width of each real/imag component (two's complement)
//   SKIP_DC  when 1, bin 0 is excluded from the peak search
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-low reset
//   fft_valid        frame strobe; fft_d0..fft_d15 valid this cycle
//   fft_d0..fft_d15  bin k: [2*DW-1:DW] real, [DW-1:0] imag
//   done             one-cycle pulse when a frame's result is published
//   freq             index of the peak bin, held until the next done
//   peak_mag         magnitude squared of the peak bin, held until the next done
//   busy             engine is scanning a frame
//   drop             one-cycle pulse when an unconsumed pending frame is overwritten

module fas_peak_detect #(
  parameter int unsigned DW      = 16,
  parameter bit          SKIP_DC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic [2*DW-1:0] peak_mag,
  output logic            busy,
  output logic            drop
);

  localparam int unsigned NumBins = 16;
  localparam int unsigned MW      = 2 * DW;

  // First bin that may win; with DC skipped an all-zero frame reports bin 1.
  localparam logic [3:0] ArgInit = SKIP_DC ? 4'd1 : 4'd0;

  typedef enum logic [0:0] {
    StIdle,
    StCalc
  } state_e;

  state_e state;

  logic [3:0]    idx;
  logic          pend_v;
  logic [MW-1:0] max_mag;
  logic [3:0]    arg;

  logic [MW-1:0] work_buf [NumBins];
  logic [MW-1:0] pend_buf [NumBins];
  logic [MW-1:0] in_frame [NumBins];

  // Gather the flat input ports into an array for bulk buffer loads.
  always_comb begin
    in_frame[0]  = fft_d0;
    in_frame[1]  = fft_d1;
    in_frame[2]  = fft_d2;
    in_frame[3]  = fft_d3;
    in_frame[4]  = fft_d4;
    in_frame[5]  = fft_d5;
    in_frame[6]  = fft_d6;
    in_frame[7]  = fft_d7;
    in_frame[8]  = fft_d8;
    in_frame[9]  = fft_d9;
    in_frame[10] = fft_d10;
    in_frame[11] = fft_d11;
    in_frame[12] = fft_d12;
    in_frame[13] = fft_d13;
    in_frame[14] = fft_d14;
    in_frame[15] = fft_d15;
  end

  // ---------------------------------------------------------------------------------------------
  // Magnitude of the bin currently addressed by idx
  // ---------------------------------------------------------------------------------------------
  logic [MW-1:0] cur_bin;
  logic [DW-1:0] cur_re;
  logic [DW-1:0] cur_im;
  logic [MW-1:0] re_ext;
  logic [MW-1:0] im_ext;
  logic [MW-1:0] re_sq;
  logic [MW-1:0] im_sq;
  logic [MW-1:0] cur_mag;

  always_comb begin
    cur_bin = work_buf[idx];
    cur_re  = cur_bin[MW-1:DW];
    cur_im  = cur_bin[DW-1:0];
    // Sign-extending to full width makes the modular low half of the product equal to the
    // signed square, which always fits in MW bits.
    re_ext  = {{DW{cur_re[DW-1]}}, cur_re};
    im_ext  = {{DW{cur_im[DW-1]}}, cur_im};
    re_sq   = re_ext * re_ext;
    im_sq   = im_ext * im_ext;
    // Largest sum is 2^(MW-1) (both components at the most negative value): no overflow.
    cur_mag = re_sq + im_sq;
  end

  // ---------------------------------------------------------------------------------------------
  // Running-maximum update for this cycle
  // ---------------------------------------------------------------------------------------------
  logic          bin_eligible;
  logic          take_bin;
  logic [MW-1:0] max_nx;
  logic [3:0]    arg_nx;
  logic          last_bin;

  always_comb begin
    bin_eligible = (idx != 4'd0) || !SKIP_DC;
    // Strict compare: on a tie the earlier (lower) index is kept.
    take_bin     = bin_eligible && (cur_mag > max_mag);
    max_nx       = take_bin ? cur_mag : max_mag;
    arg_nx       = take_bin ? idx : arg;
    last_bin     = (state == StCalc) && (idx == 4'(NumBins - 1));
  end

  // ---------------------------------------------------------------------------------------------
  // Buffer load decisions
  // ---------------------------------------------------------------------------------------------
  logic load_work_in;
  logic load_work_pend;
  logic load_pend;

  always_comb begin
    load_work_in   = 1'b0;
    load_work_pend = 1'b0;
    load_pend      = 1'b0;
    if (rst) begin
      unique case (state)
        StIdle: begin
          load_work_in = fft_valid;
        end
        StCalc: begin
          if (last_bin) begin
            // The waiting frame has priority; a simultaneous strobe then refills pending.
            load_work_pend = pend_v;
            load_work_in   = !pend_v && fft_valid;
            load_pend      = pend_v && fft_valid;
          end else begin
            load_pend = fft_valid;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame storage carries no control meaning on its own, so it is left out of reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumBins; k++) begin
      if (load_work_in) begin
        work_buf[k] <= in_frame[k];
      end else if (load_work_pend) begin
        work_buf[k] <= pend_buf[k];
      end
      if (load_pend) begin
        pend_buf[k] <= in_frame[k];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= StIdle;
      idx      <= 4'd0;
      pend_v   <= 1'b0;
      max_mag  <= '0;
      arg      <= ArgInit;
      done     <= 1'b0;
      freq     <= 4'd0;
      peak_mag <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      done <= 1'b0;
      drop <= 1'b0;
      unique case (state)
        StIdle: begin
          if (fft_valid) begin
            state   <= StCalc;
            busy    <= 1'b1;
            idx     <= 4'd0;
            max_mag <= '0;
            arg     <= ArgInit;
          end
        end
        StCalc: begin
          if (last_bin) begin
            // Publish including bin 15, then restart the scan in the same edge so a
            // reloaded frame keeps the 16-cycle cadence.
            done     <= 1'b1;
            freq     <= arg_nx;
            peak_mag <= max_nx;
            idx      <= 4'd0;
            max_mag  <= '0;
            arg      <= ArgInit;
            if (pend_v) begin
              pend_v <= fft_valid;
            end else if (!fft_valid) begin
              state <= StIdle;
              busy  <= 1'b0;
            end
          end else begin
            idx     <= idx + 4'd1;
            max_mag <= max_nx;
            arg     <= arg_nx;
            if (fft_valid) begin
              pend_v <= 1'b1;
              drop   <= pend_v;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fas_peak_detect.sv
// Self-checking bench for fas_peak_detect. Two instances share the stimulus, one with DC
// skipped and one without. A frame-level reference model schedules frames by time and
// computes each frame's peak with plain arithmetic over the 16 bins.

module tb_fas_peak_detect;

  localparam int DW = 16;

  typedef logic [15:0][31:0] frame_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   fft_valid = 1'b0;
  frame_t in_f = '0;

  logic        done1, busy1, drop1;
  logic [3:0]  freq1;
  logic [31:0] mag1;
  logic        done0, busy0, drop0;
  logic [3:0]  freq0;
  logic [31:0] mag0;

  always #5 clk = ~clk;

  fas_peak_detect #(.DW(DW), .SKIP_DC(1'b1)) dut_skip (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(in_f[0]), .fft_d1(in_f[1]), .fft_d2(in_f[2]), .fft_d3(in_f[3]),
    .fft_d4(in_f[4]), .fft_d5(in_f[5]), .fft_d6(in_f[6]), .fft_d7(in_f[7]),
    .fft_d8(in_f[8]), .fft_d9(in_f[9]), .fft_d10(in_f[10]), .fft_d11(in_f[11]),
    .fft_d12(in_f[12]), .fft_d13(in_f[13]), .fft_d14(in_f[14]), .fft_d15(in_f[15]),
    .done(done1), .freq(freq1), .peak_mag(mag1), .busy(busy1), .drop(drop1)
  );

  fas_peak_detect #(.DW(DW), .SKIP_DC(1'b0)) dut_dc (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(in_f[0]), .fft_d1(in_f[1]), .fft_d2(in_f[2]), .fft_d3(in_f[3]),
    .fft_d4(in_f[4]), .fft_d5(in_f[5]), .fft_d6(in_f[6]), .fft_d7(in_f[7]),
    .fft_d8(in_f[8]), .fft_d9(in_f[9]), .fft_d10(in_f[10]), .fft_d11(in_f[11]),
    .fft_d12(in_f[12]), .fft_d13(in_f[13]), .fft_d14(in_f[14]), .fft_d15(in_f[15]),
    .done(done0), .freq(freq0), .peak_mag(mag0), .busy(busy0), .drop(drop0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Peak of one frame straight from the definition: {arg, magnitude}.
  function automatic logic [35:0] ref_peak(input frame_t f, input bit skip);
    longint best = 0;
    int     best_k = skip ? 1 : 0;
    for (int k = (skip ? 1 : 0); k < 16; k++) begin
      shortint re16 = f[k][31:16];
      shortint im16 = f[k][15:0];
      longint  re = re16;
      longint  im = im16;
      longint  m = re * re + im * im;
      if (m > best) begin
        best   = m;
        best_k = k;
      end
    end
    return {4'(best_k), 32'(best)};
  endfunction

  // Frame-level model: an active frame finishing at a known cycle plus one pending slot.
  int          cyc = 0;
  bit          m_active = 0;
  int          m_finish = 0;
  frame_t      m_act;
  bit          m_pend_v = 0;
  frame_t      m_pend;
  bit          e_done = 0, e_drop = 0;
  logic [35:0] e_res1 = '0, e_res0 = '0;

  task automatic model_edge(input logic v, input frame_t f, input logic r);
    e_done = 0;
    e_drop = 0;
    if (!r) begin
      m_active = 0;
      m_pend_v = 0;
      e_res1   = '0;
      e_res0   = '0;
    end else if (m_active && m_finish == cyc) begin
      e_done = 1;
      e_res1 = ref_peak(m_act, 1'b1);
      e_res0 = ref_peak(m_act, 1'b0);
      if (m_pend_v) begin
        m_act    = m_pend;
        m_finish = cyc + 16;
        if (v) m_pend = f;
        else m_pend_v = 0;
      end else if (v) begin
        m_act    = f;
        m_finish = cyc + 16;
      end else begin
        m_active = 0;
      end
    end else if (v) begin
      if (!m_active) begin
        m_active = 1;
        m_act    = f;
        m_finish = cyc + 16;
      end else begin
        e_drop   = m_pend_v;
        m_pend   = f;
        m_pend_v = 1;
      end
    end
  endtask

  task automatic step(input logic v, input frame_t f, input logic r);
    @(negedge clk);
    rst       = r;
    fft_valid = v;
    in_f      = f;
    @(posedge clk);
    cyc++;
    model_edge(v, f, r);
    #1;
    check_eq("done_skip", 64'(done1), 64'(e_done));
    check_eq("drop_skip", 64'(drop1), 64'(e_drop));
    check_eq("busy_skip", 64'(busy1), 64'(m_active));
    check_eq("freq_skip", 64'(freq1), 64'(e_res1[35:32]));
    check_eq("mag_skip", 64'(mag1), 64'(e_res1[31:0]));
    check_eq("done_dc", 64'(done0), 64'(e_done));
    check_eq("drop_dc", 64'(drop0), 64'(e_drop));
    check_eq("busy_dc", 64'(busy0), 64'(m_active));
    check_eq("freq_dc", 64'(freq0), 64'(e_res0[35:32]));
    check_eq("mag_dc", 64'(mag0), 64'(e_res0[31:0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < 16; k++) begin
      int sel = int'($urandom_range(0, 9));
      logic [15:0] re, im;
      if (sel < 2) begin
        f[k] = '0;
      end else if (sel < 5) begin
        re   = 16'($signed(int'($urandom_range(0, 6)) - 3));
        im   = 16'($signed(int'($urandom_range(0, 6)) - 3));
        f[k] = {re, im};
      end else if (sel < 6 && k > 0) begin
        f[k] = f[k-1];
      end else begin
        f[k] = $urandom;
      end
    end
    return f;
  endfunction

  initial begin
    frame_t f, a, b, c;
    idle(0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    idle(2);

    // Single peak at bin 5.
    f = '0; f[5] = 32'h0100_0000;
    step(1'b1, f, 1'b1); idle(20);
    // Tie between bins 1 and 15 over a low floor.
    f = {16{32'h0010_0010}}; f[1] = 32'h0200_0000; f[15] = 32'h0200_0000;
    step(1'b1, f, 1'b1); idle(18);
    // Large DC bin against a modest bin 9.
    f = '0; f[0] = 32'h7FFF_7FFF; f[9] = 32'h0000_0300;
    step(1'b1, f, 1'b1); idle(18);
    // Most negative components.
    f = '0; f[3] = 32'h8000_8000;
    step(1'b1, f, 1'b1); idle(18);
    // All-zero frame.
    step(1'b1, '0, 1'b1); idle(18);

    // Back-to-back frames every 16 cycles, peaks 2, 7, 11, 4.
    f = '0; f[2] = 32'h0040_0000; step(1'b1, f, 1'b1); idle(15);
    f = '0; f[7] = 32'h0000_0050; step(1'b1, f, 1'b1); idle(15);
    f = '0; f[11] = 32'h0030_0030; step(1'b1, f, 1'b1); idle(15);
    f = '0; f[4] = 32'hFF00_0000; step(1'b1, f, 1'b1); idle(20);

    // Three strobes in one scan window: B is overwritten by C.
    a = '0; a[6] = 32'h0005_0000;
    b = '0; b[8] = 32'h0006_0000;
    c = '0; c[13] = 32'h0007_0000;
    step(1'b1, a, 1'b1); idle(3);
    step(1'b1, b, 1'b1); idle(3);
    step(1'b1, c, 1'b1); idle(40);

    // Reset mid-scan with a pending frame, then a clean frame.
    step(1'b1, a, 1'b1); idle(3);
    step(1'b1, b, 1'b1); idle(3);
    step(1'b0, '0, 1'b0);
    idle(3);
    step(1'b1, c, 1'b1); idle(20);

    // Random traffic in phases of varying strobe density.
    for (int ph = 0; ph < 30; ph++) begin
      int dens = int'($urandom_range(0, 3));
      for (int i = 0; i < 100; i++) begin
        logic v;
        unique case (dens)
          0: v = ($urandom_range(0, 19) == 0);
          1: v = ($urandom_range(0, 5) == 0);
          2: v = ((cyc % 16) == 0);
          default: v = ($urandom_range(0, 1) == 0);
        endcase
        if ($urandom_range(0, 399) == 0) step(1'b0, '0, 1'b0);
        else step(v, rand_frame(), 1'b1);
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fas_peak_detect.md
Name: fas_peak_detect

Overview:
- Frequency-analysis stage that sits directly downstream of the FAS 16-point FFT.
- Accepts one 16-bin complex FFT frame per fft_valid strobe and computes |X[k]|^2 for each bin, one bin per cycle.
- Reports the index of the strongest bin on freq, with a one-cycle done pulse.
- Double-buffered, so frames arriving every 16 cycles are processed back-to-back without loss.

Parameters:
- DW, 16, width of each real/imag component (two's complement).
- SKIP_DC, 1, when 1 bin 0 is excluded from the peak search.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- fft_valid  input  1  frame strobe; fft_d0..fft_d15 are valid in this cycle.
- fft_d0..fft_d15  input  2*DW each  bin k; [2*DW-1:DW] real, [DW-1:0] imag.
- done  output  1  one-cycle pulse; freq/peak_mag valid for the completed frame.
- freq  output  4  index of the peak bin; held until the next done.
- peak_mag  output  2*DW  re^2+im^2 of the peak bin (unsigned); held until the next done.
- busy  output  1  engine is in CALC.
- drop  output  1  one-cycle pulse when a pending frame is overwritten.

Behaviour:
- Reset: done=0, freq=0, peak_mag=0, busy=0, drop=0; state=IDLE, idx=0, pend_v=0, running max=0. Reset mid-frame discards the work and pending buffers; no done is issued for the aborted frame.
- Storage:
  - work buffer: 16 x 2*DW, the frame being scanned.
  - pending buffer: 16 x 2*DW plus pend_v, one waiting frame.
- States: IDLE, CALC.
- IDLE:
  - fft_valid at edge T loads the inputs into the work buffer; idx=0, max=0, arg=(SKIP_DC?1:0); go to CALC.
  - busy=1 from T.
- CALC:
  - Each edge evaluates bin idx: m = re*re + im*im, signed DW x DW products, summed unsigned 2*DW bits, no overflow since the maximum is 2^(2*DW-1).
  - Update: if (idx!=0 or SKIP_DC==0) and m > max (strict), then max=m, arg=idx. Ties keep the lower index.
  - idx increments by 1.
- Final edge (idx==15, edge T+16):
  - done=1, freq=arg, peak_mag=max, using the updated values including bin 15.
  - Next frame source, in priority order:
    - pend_v: load pending into work; if fft_valid is also high, the input goes to pending (pend_v stays 1), otherwise pend_v=0.
    - else fft_valid: load the inputs into work directly.
    - else: go to IDLE, busy=0.
  - A reloaded frame restarts idx=0 and max=0 in the same edge, so done pulses exactly every 16 cycles under continuous input.
- fft_valid in CALC, not on the final edge:
  - pend_v==0: capture to pending, pend_v=1.
  - pend_v==1: overwrite pending, drop=1 for one cycle; the older pending frame is lost.
- Latency: fft_valid at edge T (engine idle) gives done high in the cycle following edge T+16.
- done, drop: cleared on every edge where not set.
- All zero frame: max stays 0, freq = (SKIP_DC?1:0), peak_mag=0.

Test Plan:
- Single frame, bin 5 = 0x0100_0000 (re=1.0 in 8.8), others 0 -> done 16 cycles after fft_valid, freq=5, peak_mag=0x00010000, busy low afterwards.
- Bins 1 and 15 both 0x0200_0000, others 0x0010_0010 -> freq=1 (tie goes to lower index), peak_mag=0x00040000.
- SKIP_DC=1: bin 0 = 0x7FFF_7FFF, bin 9 = 0x0000_0300 -> freq=9, peak_mag=0x00090000. With SKIP_DC=0 the same frame -> freq=0.
- Extremes: bin 3 = 0x8000_8000 -> peak_mag=0x80000000, freq=3, no overflow.
- Back-to-back frames with fft_valid every 16 cycles, peaks 2, 7, 11, 4 -> four done pulses 16 cycles apart, freq 2, 7, 11, 4, drop never asserted.
- Three fft_valid strobes within one CALC window (frames A, B, C) -> one drop pulse on C; done sequence reports A, then C; B never reported.
- rst=0 at cycle 8 of CALC with a pending frame -> all outputs 0, no done; next fft_valid is processed normally.
